// File: rtl/f0_clc_gen.sv
// Fetch stage 0: owns the fetch PC, applies redirects and produces the
// even/odd cache-line-candidate pair plus redirect epoch for stage f1.
//
// state  | meaning
// -------+-------------------------------------------------------------
// RESET  | leaving reset; moves to RUN on the first edge, redirects ignored
// RUN    | presenting a live fetch; advances, stalls, halts or redirects
// HALTED | fetching stopped by halt_in; only a redirect leaves
// FAULT  | redirect target was misaligned; only a redirect leaves
module f0_clc_gen #(
  parameter int                XLEN         = 32,
  parameter int                CLC_WIDTH    = 28,
  parameter logic [XLEN-1:0]   RESET_VECTOR = 32'h0000_1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_in,
  input  logic                 halt_in,
  input  logic                 redirect_be_valid,
  input  logic [XLEN-1:0]      redirect_be_pc,
  input  logic                 redirect_fe_valid,
  input  logic [XLEN-1:0]      redirect_fe_pc,
  output logic [XLEN-1:0]      pc_out,
  output logic                 fetch_valid,
  output logic [CLC_WIDTH-1:0] clc_even_out,
  output logic [CLC_WIDTH-1:0] clc_odd_out,
  output logic                 clc_even_valid,
  output logic                 clc_odd_valid,
  output logic [1:0]           epoch_out,
  output logic                 exception_out
);

  localparam int              OFF       = XLEN - CLC_WIDTH;
  localparam logic [XLEN-1:0] FETCH_INC = {{(XLEN-1){1'b0}}, 1'b1} << OFF;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [1:0]      epoch_q, epoch_d;

  logic            redirect;
  logic [XLEN-1:0] redirect_pc;

  // Backend redirect outranks the frontend one; only one epoch bump per edge.
  always_comb begin
    redirect    = redirect_be_valid | redirect_fe_valid;
    redirect_pc = redirect_be_valid ? redirect_be_pc : redirect_fe_pc;
  end

  // Next-state, next-PC and next-epoch selection.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epoch_d = epoch_q;
    if (state_q == ST_RESET) begin
      state_d = ST_RUN;
    end else if (redirect) begin
      pc_d    = redirect_pc;
      epoch_d = epoch_q + 2'd1;
      state_d = redirect_pc[0] ? ST_FAULT : ST_RUN;
    end else if (state_q == ST_RUN) begin
      if (halt_in) begin
        state_d = ST_HALTED;
      end else if (!stall_in) begin
        pc_d = pc_q + FETCH_INC;
      end
    end
  end

  // State, PC and epoch registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RESET;
      pc_q    <= RESET_VECTOR;
      epoch_q <= 2'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epoch_q <= epoch_d;
    end
  end

  logic [CLC_WIDTH-1:0] line_l, line_l1;
  logic                 aligned;

  // Line-candidate decode; indices are placed by parity, valids depend on
  // whether the fetch block straddles into the next line.
  always_comb begin
    line_l  = pc_q[XLEN-1:OFF];
    line_l1 = line_l + {{(CLC_WIDTH-1){1'b0}}, 1'b1};
    aligned = (pc_q[OFF-1:0] == '0);

    pc_out        = pc_q;
    epoch_out     = epoch_q;
    fetch_valid   = (state_q == ST_RUN);
    exception_out = (state_q == ST_FAULT);

    clc_even_out   = line_l[0] ? line_l1 : line_l;
    clc_odd_out    = line_l[0] ? line_l  : line_l1;
    clc_even_valid = fetch_valid & (~aligned | ~line_l[0]);
    clc_odd_valid  = fetch_valid & (~aligned |  line_l[0]);
  end

endmodule

// File: tb/tb_f0_clc_gen.sv
// Self-checking bench for f0_clc_gen: directed scenarios followed by a
// randomized run compared against a behavioural model of the fetch stage.
module tb_f0_clc_gen;

  localparam logic [31:0] RV = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in, halt_in;
  logic        redirect_be_valid, redirect_fe_valid;
  logic [31:0] redirect_be_pc, redirect_fe_pc;
  logic [31:0] pc_out;
  logic        fetch_valid, clc_even_valid, clc_odd_valid, exception_out;
  logic [27:0] clc_even_out, clc_odd_out;
  logic [1:0]  epoch_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  f0_clc_gen dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .halt_in(halt_in),
    .redirect_be_valid(redirect_be_valid), .redirect_be_pc(redirect_be_pc),
    .redirect_fe_valid(redirect_fe_valid), .redirect_fe_pc(redirect_fe_pc),
    .pc_out(pc_out), .fetch_valid(fetch_valid),
    .clc_even_out(clc_even_out), .clc_odd_out(clc_odd_out),
    .clc_even_valid(clc_even_valid), .clc_odd_valid(clc_odd_valid),
    .epoch_out(epoch_out), .exception_out(exception_out)
  );

  // Behavioural model: mode names what the fetch stage is doing.
  localparam int M_RESET = 0, M_RUN = 1, M_HALT = 2, M_FAULT = 3;
  logic [31:0] m_pc;
  logic [1:0]  m_ep;
  int          m_mode;
  logic        e_fv, e_exc, e_ev, e_ov;
  logic [27:0] e_even, e_odd;

  function automatic void model_reset();
    m_pc = RV; m_ep = 2'd0; m_mode = M_RESET;
  endfunction

  function automatic void model_take(input logic [31:0] t);
    m_pc = t; m_ep = m_ep + 2'd1;
    m_mode = t[0] ? M_FAULT : M_RUN;
  endfunction

  function automatic void model_step();
    if (rst) model_reset();
    else if (m_mode == M_RESET) m_mode = M_RUN;
    else if (redirect_be_valid) model_take(redirect_be_pc);
    else if (redirect_fe_valid) model_take(redirect_fe_pc);
    else if (m_mode == M_RUN) begin
      if (halt_in) m_mode = M_HALT;
      else if (!stall_in) m_pc = m_pc + 32'd16;
    end
  endfunction

  // The fetch block covers bytes pc..pc+15; the lines holding the first and
  // last byte are what is needed, placed on the even/odd side by parity.
  function automatic void model_expect();
    logic [31:0] last_byte;
    logic [27:0] first_line, last_line, next_line;
    last_byte  = m_pc + 32'd15;
    first_line = m_pc[31:4];
    last_line  = last_byte[31:4];
    next_line  = first_line + 28'd1;
    e_fv   = (m_mode == M_RUN);
    e_exc  = (m_mode == M_FAULT);
    e_even = (first_line % 2 == 0) ? first_line : next_line;
    e_odd  = (first_line % 2 == 1) ? first_line : next_line;
    e_ev   = e_fv && ((first_line % 2 == 0) || (last_line % 2 == 0));
    e_ov   = e_fv && ((first_line % 2 == 1) || (last_line % 2 == 1));
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    stall_in = 0; halt_in = 0;
    redirect_be_valid = 0; redirect_fe_valid = 0;
    redirect_be_pc = '0; redirect_fe_pc = '0;
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs();
    #1; model_reset();
    tick();
    checks++; if (fetch_valid !== 1'b0 || clc_even_valid !== 1'b0 || clc_odd_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valids: fv=%b ev=%b ov=%b want 000", fetch_valid, clc_even_valid, clc_odd_valid); end
    checks++; if (pc_out !== RV || epoch_out !== 2'd0 || exception_out !== 1'b0) begin
      errors++; $display("FAIL reset_vals: pc=%h ep=%0d exc=%b want %h 0 0", pc_out, epoch_out, exception_out, RV); end
    rst = 0;
    tick();
    checks++; if (fetch_valid !== 1'b1 || pc_out !== RV) begin
      errors++; $display("FAIL first_fetch: fv=%b pc=%h want 1 %h", fetch_valid, pc_out, RV); end
    checks++; if (clc_even_out !== 28'h100 || clc_even_valid !== 1'b1 || clc_odd_valid !== 1'b0 || clc_odd_out !== 28'h101) begin
      errors++; $display("FAIL first_clc: even=%h/%b odd=%h/%b want 100/1 101/0", clc_even_out, clc_even_valid, clc_odd_out, clc_odd_valid); end
  endtask

  task automatic test_sequential();
    tick();
    checks++; if (pc_out !== 32'h1010) begin errors++; $display("FAIL seq_pc1: got %h want 00001010", pc_out); end
    checks++; if (clc_odd_valid !== 1'b1 || clc_even_valid !== 1'b0 || clc_odd_out !== 28'h101) begin
      errors++; $display("FAIL seq_clc1: odd=%h/%b ev=%b want 101/1 0", clc_odd_out, clc_odd_valid, clc_even_valid); end
    tick();
    checks++; if (pc_out !== 32'h1020) begin errors++; $display("FAIL seq_pc2: got %h want 00001020", pc_out); end
  endtask

  task automatic test_fe_unaligned();
    redirect_fe_valid = 1; redirect_fe_pc = 32'h2008;
    tick();
    redirect_fe_valid = 0;
    checks++; if (pc_out !== 32'h2008 || epoch_out !== 2'd1) begin
      errors++; $display("FAIL fe_redirect: pc=%h ep=%0d want 00002008 1", pc_out, epoch_out); end
    checks++; if (clc_even_out !== 28'h200 || clc_odd_out !== 28'h201 || clc_even_valid !== 1'b1 || clc_odd_valid !== 1'b1) begin
      errors++; $display("FAIL fe_clc: even=%h/%b odd=%h/%b want 200/1 201/1", clc_even_out, clc_even_valid, clc_odd_out, clc_odd_valid); end
    tick();
    checks++; if (pc_out !== 32'h2018) begin errors++; $display("FAIL fe_advance: got %h want 00002018", pc_out); end
  endtask

  task automatic test_both_redirect_stall();
    stall_in = 1;
    redirect_be_valid = 1; redirect_be_pc = 32'h3000;
    redirect_fe_valid = 1; redirect_fe_pc = 32'h4000;
    tick();
    redirect_be_valid = 0; redirect_fe_valid = 0;
    checks++; if (pc_out !== 32'h3000 || epoch_out !== 2'd2 || fetch_valid !== 1'b1) begin
      errors++; $display("FAIL both_redirect: pc=%h ep=%0d fv=%b want 00003000 2 1", pc_out, epoch_out, fetch_valid); end
  endtask

  task automatic test_stall();
    stall_in = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (pc_out !== 32'h3000 || epoch_out !== 2'd2 || fetch_valid !== 1'b1 ||
                    clc_even_out !== 28'h300 || clc_even_valid !== 1'b1 || clc_odd_valid !== 1'b0 || clc_odd_out !== 28'h301) begin
        errors++; $display("FAIL stall_hold[%0d]: pc=%h ep=%0d fv=%b ev=%h/%b ov=%h/%b", i, pc_out, epoch_out,
                           fetch_valid, clc_even_out, clc_even_valid, clc_odd_out, clc_odd_valid); end
    end
    stall_in = 0;
    tick();
    checks++; if (pc_out !== 32'h3010) begin errors++; $display("FAIL stall_release: got %h want 00003010", pc_out); end
  endtask

  task automatic test_halt();
    halt_in = 1;
    tick();
    checks++; if (fetch_valid !== 1'b0 || clc_even_valid !== 1'b0 || clc_odd_valid !== 1'b0 || pc_out !== 32'h3010) begin
      errors++; $display("FAIL halt_enter: fv=%b ev=%b ov=%b pc=%h want 0 0 0 00003010", fetch_valid, clc_even_valid, clc_odd_valid, pc_out); end
    for (int i = 0; i < 3; i++) begin
      halt_in = 1'($urandom_range(0, 1)); stall_in = 1'($urandom_range(0, 1));
      tick();
      checks++; if (fetch_valid !== 1'b0 || pc_out !== 32'h3010) begin
        errors++; $display("FAIL halt_hold[%0d]: fv=%b pc=%h want 0 00003010", i, fetch_valid, pc_out); end
    end
    halt_in = 1; stall_in = 0;
    redirect_be_valid = 1; redirect_be_pc = 32'h5000;
    tick();
    redirect_be_valid = 0; halt_in = 0;
    checks++; if (fetch_valid !== 1'b1 || pc_out !== 32'h5000 || epoch_out !== 2'd3) begin
      errors++; $display("FAIL halt_exit: fv=%b pc=%h ep=%0d want 1 00005000 3", fetch_valid, pc_out, epoch_out); end
  endtask

  task automatic test_fault();
    redirect_fe_valid = 1; redirect_fe_pc = 32'h6001;
    tick();
    redirect_fe_valid = 0;
    checks++; if (exception_out !== 1'b1 || fetch_valid !== 1'b0 || pc_out !== 32'h6001 || epoch_out !== 2'd0) begin
      errors++; $display("FAIL fault_enter: exc=%b fv=%b pc=%h ep=%0d want 1 0 00006001 0", exception_out, fetch_valid, pc_out, epoch_out); end
    checks++; if (clc_even_valid !== 1'b0 || clc_odd_valid !== 1'b0) begin
      errors++; $display("FAIL fault_valids: ev=%b ov=%b want 0 0", clc_even_valid, clc_odd_valid); end
    halt_in = 1; stall_in = 1;
    tick(); tick();
    checks++; if (exception_out !== 1'b1 || pc_out !== 32'h6001) begin
      errors++; $display("FAIL fault_hold: exc=%b pc=%h want 1 00006001", exception_out, pc_out); end
    halt_in = 0; stall_in = 0;
    redirect_fe_valid = 1; redirect_fe_pc = 32'h6000;
    tick();
    redirect_fe_valid = 0;
    checks++; if (exception_out !== 1'b0 || fetch_valid !== 1'b1 || pc_out !== 32'h6000 || epoch_out !== 2'd1) begin
      errors++; $display("FAIL fault_exit: exc=%b fv=%b pc=%h ep=%0d want 0 1 00006000 1", exception_out, fetch_valid, pc_out, epoch_out); end
  endtask

  task automatic test_wrap();
    redirect_be_valid = 1; redirect_be_pc = 32'hFFFF_FFF8;
    tick();
    redirect_be_valid = 0;
    checks++; if (clc_even_out !== 28'h0000000 || clc_odd_out !== 28'hFFFFFFF || clc_even_valid !== 1'b1 || clc_odd_valid !== 1'b1) begin
      errors++; $display("FAIL wrap_clc: even=%h/%b odd=%h/%b want 0000000/1 fffffff/1", clc_even_out, clc_even_valid, clc_odd_out, clc_odd_valid); end
    tick();
    checks++; if (pc_out !== 32'h0000_0008) begin errors++; $display("FAIL wrap_pc: got %h want 00000008", pc_out); end
  endtask

  task automatic test_mid_reset();
    redirect_fe_valid = 1; redirect_fe_pc = 32'h7000;
    rst = 1;
    #1; model_reset();
    checks++; if (pc_out !== RV || fetch_valid !== 1'b0 || epoch_out !== 2'd0) begin
      errors++; $display("FAIL async_reset: pc=%h fv=%b ep=%0d want %h 0 0", pc_out, fetch_valid, epoch_out, RV); end
    tick();
    rst = 0;
    tick();
    redirect_fe_valid = 0;
    checks++; if (pc_out !== RV || epoch_out !== 2'd0 || fetch_valid !== 1'b1) begin
      errors++; $display("FAIL reset_exit_redirect_ignored: pc=%h ep=%0d fv=%b want %h 0 1", pc_out, epoch_out, fetch_valid, RV); end
  endtask

  task automatic test_random();
    logic [31:0] t;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst      = ($urandom_range(0, 149) == 0);
      stall_in = ($urandom_range(0, 2) == 0);
      halt_in  = ($urandom_range(0, 9) == 0);
      redirect_be_valid = ($urandom_range(0, 11) == 0);
      redirect_fe_valid = ($urandom_range(0, 7) == 0);
      t = $urandom;
      case ($urandom_range(0, 3))
        0: t[3:0] = 4'h0;
        1: t[0]   = 1'b0;
        default: ;
      endcase
      redirect_be_pc = t;
      redirect_fe_pc = $urandom & 32'hFFFF_FFFE;
      tick();
      model_expect();
      checks++;
      if (pc_out !== m_pc || epoch_out !== m_ep || fetch_valid !== e_fv || exception_out !== e_exc ||
          clc_even_out !== e_even || clc_odd_out !== e_odd || clc_even_valid !== e_ev || clc_odd_valid !== e_ov) begin
        errors++;
        $display("FAIL random[%0d]: pc %h/%h ep %0d/%0d fv %b/%b exc %b/%b even %h/%h %b/%b odd %h/%h %b/%b (got/want)",
                 cyc, pc_out, m_pc, epoch_out, m_ep, fetch_valid, e_fv, exception_out, e_exc,
                 clc_even_out, e_even, clc_even_valid, e_ev, clc_odd_out, e_odd, clc_odd_valid, e_ov);
      end
    end
    rst = 0; clear_inputs();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_fe_unaligned();
    test_both_redirect_stall();
    test_stall();
    test_halt();
    test_fault();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
